// File: rtl/filter_8b_4tap_pkg.sv
// Shared constants for the 4-tap (1,2,3,4) FIR link: widths, coefficients,
// decoder state encoding and the 8-bit saturation helper.
package filter_8b_4tap_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_YW   = 12;
    localparam int DEF_CNTW = 16;

    localparam int COEFF_0 = 1;
    localparam int COEFF_1 = 2;
    localparam int COEFF_2 = 3;
    localparam int COEFF_3 = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam int SAT_RW = DEF_YW + 3;

    function automatic logic [DEF_DW-1:0] sat8(input logic signed [SAT_RW-1:0] r);
        if (r[SAT_RW-1]) begin
            return '0;
        end else if (r > SAT_RW'((1 << DEF_DW) - 1)) begin
            return '1;
        end else begin
            return r[DEF_DW-1:0];
        end
    endfunction

endpackage

// File: rtl/filter_hist3.sv
// Three-deep history of recovered samples; x1 is the most recent.
module filter_hist3
    import filter_8b_4tap_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] x1_o,
    output logic [DW-1:0] x2_o,
    output logic [DW-1:0] x3_o
);

    logic [DW-1:0] x1_q, x2_q, x3_q;

    // Clear has priority so a frame start always begins from zero history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
        end else if (clr_i) begin
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
        end else if (load_i) begin
            x3_q <= x2_q;
            x2_q <= x1_q;
            x1_q <= din_i;
        end
    end

    assign x1_o = x1_q;
    assign x2_o = x2_q;
    assign x3_o = x3_q;

endmodule

// File: rtl/filter_8b_4tap_deconv.sv
// Streaming inverse of the 1,2,3,4 FIR: x[n] = y[n] - 2x[n-1] - 3x[n-2] - 4x[n-3],
// with a sticky error and lockout when a word cannot come from a legal 8-bit stream.
module filter_8b_4tap_deconv
    import filter_8b_4tap_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int YW   = DEF_YW,
    parameter int C1   = COEFF_1,
    parameter int C2   = COEFF_2,
    parameter int C3   = COEFF_3,
    parameter int CNTW = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sync,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [YW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            err,
    output logic [CNTW-1:0] sample_cnt,
    output logic [1:0]      dbg_state
);

    // Handshake: a word moves on a channel in any cycle where valid and ready are both
    // high at the rising edge; valid never depends on ready, and data is held while
    // valid is high and ready is low.

    localparam int RW = YW + 3;
    localparam logic signed [RW-1:0] K1    = RW'(C1);
    localparam logic signed [RW-1:0] K2    = RW'(C2);
    localparam logic signed [RW-1:0] K3    = RW'(C3);
    localparam logic signed [RW-1:0] R_MAX = RW'((1 << DW) - 1);

    logic [1:0]      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [DW-1:0]   x1, x2, x3;
    logic signed [RW-1:0] y_s, x1_s, x2_s, x3_s, r;
    logic            r_neg, r_hi, out_of_range;
    logic [DW-1:0]   sat_val;
    logic            accept, out_fire;

    assign in_ready = (state_q != ST_ERR) && (!out_valid_q || out_ready) && !sync;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // Full-width signed recurrence; nothing is truncated before the range check.
    assign y_s  = $signed({{(RW-YW){1'b0}}, in_data});
    assign x1_s = $signed({{(RW-DW){1'b0}}, x1});
    assign x2_s = $signed({{(RW-DW){1'b0}}, x2});
    assign x3_s = $signed({{(RW-DW){1'b0}}, x3});
    assign r    = y_s - K1 * x1_s - K2 * x2_s - K3 * x3_s;

    assign r_neg        = r[RW-1];
    assign r_hi         = !r_neg && (r > R_MAX);
    assign out_of_range = r_neg || r_hi;
    assign sat_val      = r_neg ? '0 : (r_hi ? '1 : r[DW-1:0]);

    filter_hist3 #(.DW(DW)) u_hist (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sync),
        .load_i (accept),
        .din_i  (sat_val),
        .x1_o   (x1),
        .x2_o   (x2),
        .x3_o   (x3)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_val;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // sync leaves the output register alone so a pending sample still drains.
        if (sync) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            if (out_fire) begin
                cnt_d = cnt_q + CNTW'(1);
            end
            if (accept) begin
                state_d = out_of_range ? ST_ERR : ST_RUN;
                if (out_of_range) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign err        = err_q;
    assign sample_cnt = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_filter_8b_4tap_deconv.sv
// Bench for the FIR deconvolver: directed sequences plus a random loopback stream
// through a forward-filter model, checked every cycle against a queue-based model.
module tb_filter_8b_4tap_deconv;
    import filter_8b_4tap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        err;
    logic [15:0] sample_cnt;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;

    // Model state: recovered-sample history, pending outputs, flags.
    int         h1 = 0, h2 = 0, h3 = 0;
    bit         m_err = 0;
    int         m_cnt = 0;
    logic [1:0] m_state = ST_IDLE;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    logic [7:0] src_x[$];
    bit         rnd_done = 0;

    filter_8b_4tap_deconv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync       (sync),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err        (err),
        .sample_cnt (sample_cnt),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare and model advance, sampled on the falling edge.
    always @(negedge clk) begin
        bit exp_ready, fire, acc;
        int r, s;
        if (!rst_n) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_data", int'(out_data), 0);
            chk("rst_err", int'(err), 0);
            chk("rst_cnt", int'(sample_cnt), 0);
            exp_q.delete();
            h1 = 0; h2 = 0; h3 = 0;
            m_err = 0; m_cnt = 0; m_state = ST_IDLE;
        end else begin
            exp_ready = !m_err && (exp_q.size() == 0 || out_ready) && !sync;
            chk("in_ready", int'(in_ready), int'(exp_ready));
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("out_data", int'(out_data), int'(exp_q[0]));
            chk("err", int'(err), int'(m_err));
            chk("sample_cnt", int'(sample_cnt), m_cnt);
            chk("state", int'(dbg_state), int'(m_state));

            fire = (exp_q.size() != 0) && out_ready;
            acc  = in_valid && exp_ready;
            if (fire) begin
                got_q.push_back(out_data);
                void'(exp_q.pop_front());
            end
            if (sync) begin
                h1 = 0; h2 = 0; h3 = 0;
                m_err = 0; m_cnt = 0; m_state = ST_IDLE;
            end else begin
                if (fire) m_cnt = (m_cnt + 1) % 65536;
                if (acc) begin
                    r = int'(in_data) - 2 * h1 - 3 * h2 - 4 * h3;
                    s = (r < 0) ? 0 : ((r > 255) ? 255 : r);
                    h3 = h2; h2 = h1; h1 = s;
                    exp_q.push_back(8'(s));
                    if (s != r) begin
                        m_err = 1;
                        m_state = ST_ERR;
                    end else if (!m_err) begin
                        m_state = ST_RUN;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync();
        @(posedge clk); #1;
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
    endtask

    // Leaves in_valid high on return; callers lower it when they pause.
    task automatic send(input logic [11:0] y);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = y;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_got(input string name, input int n, input int v0, input int v1,
                           input int v2, input int v3);
        int vals[4];
        vals = '{v0, v1, v2, v3};
        chk({name, "_len"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk(name, int'(got_q[i]), vals[i]);
    endtask

    initial begin
        logic [7:0] x0, x1v, x2v, x3v;
        int y;

        idle(3);
        chk("reset_state", int'(dbg_state), int'(ST_IDLE));
        rst_n = 1'b1;
        idle(2);

        // 1: basic sequence
        pulse_sync();
        got_q.delete();
        send(12'd10); send(12'd40); send(12'd100); send(12'd200);
        in_valid = 1'b0;
        idle(3);
        chk_got("seq1", 4, 10, 20, 30, 40);
        chk("seq1_cnt", int'(sample_cnt), 4);
        chk("seq1_err", int'(err), 0);

        // 2: backpressure holds the output and blocks input
        pulse_sync();
        got_q.delete();
        out_ready = 1'b0;
        send(12'd10);
        in_data = 12'd40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_data", int'(out_data), 10);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(12'd40); send(12'd100); send(12'd200);
        in_valid = 1'b0;
        idle(3);
        chk_got("bp", 4, 10, 20, 30, 40);

        // 3: overflow locks out input until sync
        pulse_sync();
        got_q.delete();
        send(12'd300);
        in_valid = 1'b0;
        idle(3);
        chk("ovf_err", int'(err), 1);
        chk("ovf_in_ready", int'(in_ready), 0);
        chk("ovf_state", int'(dbg_state), int'(ST_ERR));
        pulse_sync();
        chk("ovf_sync_err", int'(err), 0);
        chk("ovf_sync_state", int'(dbg_state), int'(ST_IDLE));
        send(12'd5);
        in_valid = 1'b0;
        idle(3);
        chk_got("ovf", 2, 255, 5, 0, 0);

        // 4: underflow saturates to zero
        pulse_sync();
        got_q.delete();
        send(12'd5); send(12'd0);
        in_valid = 1'b0;
        idle(3);
        chk_got("udf", 2, 5, 0, 0, 0);
        chk("udf_err", int'(err), 1);

        // 5: a word presented alongside sync is not consumed
        pulse_sync();
        send(12'd50);
        in_valid = 1'b0;
        idle(3);
        @(posedge clk); #1;
        sync = 1'b1; in_valid = 1'b1; in_data = 12'd99;
        @(posedge clk); #1;
        sync = 1'b0; in_valid = 1'b0;
        got_q.delete();
        send(12'd7);
        in_valid = 1'b0;
        idle(3);
        chk_got("sync_word", 1, 7, 0, 0, 0);

        // 6: random loopback through the forward filter
        pulse_sync();
        got_q.delete();
        src_x.delete();
        x1v = 0; x2v = 0; x3v = 0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    x0 = 8'($urandom_range(0, 255));
                    src_x.push_back(x0);
                    y = int'(x0) + 2 * int'(x1v) + 3 * int'(x2v) + 4 * int'(x3v);
                    x3v = x2v; x2v = x1v; x1v = x0;
                    send(12'(y));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        idle($urandom_range(1, 3));
                    end
                end
                in_valid = 1'b0;
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(5);
        chk("rnd_len", got_q.size(), 1000);
        for (int i = 0; i < got_q.size() && i < src_x.size(); i++)
            if (got_q[i] != src_x[i]) chk("rnd_data", int'(got_q[i]), int'(src_x[i]));
        chk("rnd_err", int'(err), 0);
        chk("rnd_cnt", int'(sample_cnt), 1000);

        // Async reset with a stalled output pending
        out_ready = 1'b0;
        send(12'd3);
        in_data = 12'd9;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_cnt", int'(sample_cnt), 0);
        chk("arst_state", int'(dbg_state), int'(ST_IDLE));
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        got_q.delete();
        send(12'd5);
        in_valid = 1'b0;
        idle(3);
        chk_got("post_rst", 1, 5, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
